pc_sequencer: RTL



---
 rtl/pc_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the 16-bit RISC core with a circular return-address stack
// Ports: clock/reset (sync, active-high); stall, branch_taken/branch_offset, jump/jump_target,
//        call, ret, halt, resume requests; pc_out fetch address, flush redirect strobe,
//        halted status, sticky ras_overflow/ras_underflow flags.
module pc_sequencer #(
    parameter int PC_WIDTH     = 6,
    parameter int RESET_VECTOR = 0,
    parameter int RAS_DEPTH    = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_offset,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                call,
    input  logic                ret,
    input  logic                halt,
    input  logic                resume,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                flush,
    output logic                halted,
    output logic                ras_overflow,
    output logic                ras_underflow
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PC_WIDTH-1:0] PC_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
    typedef enum logic {RUN, HALTED} state_t;
    state_t state, state_n;
    logic [PC_WIDTH-1:0] ras [RAS_DEPTH];
    logic [AW-1:0] ptr;
    logic [CW-1:0] count;
    logic [PC_WIDTH-1:0] pc_n;
    logic flush_n, ovf_n, unf_n, push, pop;
    wire [PC_WIDTH-1:0] top = ras[ptr - PTR_ONE];
    wire [PC_WIDTH-1:0] pc_inc = pc_out + PC_ONE;
    assign halted = (state == HALTED);
    always_comb begin
        state_n = state;
        pc_n    = pc_out;
        flush_n = 1'b0;
        ovf_n   = ras_overflow;
        unf_n   = ras_underflow;
        push    = 1'b0;
        pop     = 1'b0;
        if (state == HALTED) begin
            if (resume && !halt) state_n = RUN;
        end else if (halt) begin
            state_n = HALTED;
        end else if (ret) begin
            // an empty stack degrades to a plain increment and is only flagged
            if (count != '0) begin
                pc_n    = top;
                pop     = 1'b1;
                flush_n = 1'b1;
            end else begin
                pc_n  = pc_inc;
                unf_n = 1'b1;
            end
        end else if (call) begin
            pc_n    = jump_target;
            push    = 1'b1;
            flush_n = 1'b1;
            if (count == FULL) ovf_n = 1'b1;
        end else if (jump) begin
            pc_n    = jump_target;
            flush_n = 1'b1;
        end else if (branch_taken) begin
            pc_n    = pc_out + branch_offset;
            flush_n = 1'b1;
        end else if (!stall) begin
            pc_n = pc_inc;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RUN;
            pc_out        <= PC_WIDTH'(RESET_VECTOR);
            flush         <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            ptr           <= '0;
            count         <= '0;
        end else begin
            state         <= state_n;
            pc_out        <= pc_n;
            flush         <= flush_n;
            ras_overflow  <= ovf_n;
            ras_underflow <= unf_n;
            // a push on a full stack overwrites the oldest slot, so count saturates
            if (push) begin
                ptr   <= ptr + PTR_ONE;
                count <= (count == FULL) ? FULL : count + CNT_ONE;
            end else if (pop) begin
                ptr   <= ptr - PTR_ONE;
                count <= count - CNT_ONE;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (!reset && push) ras[ptr] <= pc_inc;
    end
endmodule
